// File: rtl/piezo_seq_pkg.sv
// rtl/piezo_seq_pkg.sv - note type, FSM states and default alert melodies
package piezo_pkg;

  typedef struct packed {
    logic [15:0] half_period;
    logic [7:0]  dur;
    logic        last;
  } note_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NOTE = 2'd1,
    S_REST = 2'd2
  } state_t;

  localparam note_t SILENT_LAST = '{half_period: 16'd0, dur: 8'd1, last: 1'b1};

  localparam note_t ID0_N0 = '{half_period: 16'd8, dur: 8'd4, last: 1'b1};

  localparam note_t ID1_N0 = '{half_period: 16'd6, dur: 8'd2, last: 1'b0};
  localparam note_t ID1_N1 = '{half_period: 16'd4, dur: 8'd2, last: 1'b1};

  localparam note_t ID2_N0 = '{half_period: 16'd3, dur: 8'd1, last: 1'b0};
  localparam note_t ID2_N1 = '{half_period: 16'd0, dur: 8'd1, last: 1'b0};
  localparam note_t ID2_N2 = '{half_period: 16'd3, dur: 8'd1, last: 1'b1};

  // Unknown (id, index) pairs play a single silent tick and end the melody.
  function automatic note_t melody_note(input int unsigned id, input int unsigned idx);
    note_t n;
    n = SILENT_LAST;
    if (id == 0 && idx == 0)      n = ID0_N0;
    else if (id == 1 && idx == 0) n = ID1_N0;
    else if (id == 1 && idx == 1) n = ID1_N1;
    else if (id == 2 && idx == 0) n = ID2_N0;
    else if (id == 2 && idx == 1) n = ID2_N1;
    else if (id == 2 && idx == 2) n = ID2_N2;
    return n;
  endfunction

endpackage

// File: rtl/piezo_seq_if.sv
// rtl/piezo_seq_if.sv - alert request / piezo output bundle
interface piezo_seq_if #(
  parameter int NUM_ALERTS = 3
) ();

  localparam int ID_W = (NUM_ALERTS > 1) ? $clog2(NUM_ALERTS) : 1;

  logic [NUM_ALERTS-1:0] alert_req;
  logic                  mute;
  logic                  piezo;
  logic                  piezo_n;
  logic                  playing;
  logic [ID_W-1:0]       active_id;

  modport master (
    output alert_req, mute,
    input  piezo, piezo_n, playing, active_id
  );

  modport slave (
    input  alert_req, mute,
    output piezo, piezo_n, playing, active_id
  );

endinterface

// File: rtl/piezo_note_rom.sv
// rtl/piezo_note_rom.sv - combinational (alert id, note index) to note lookup
module piezo_note_rom
  import piezo_pkg::*;
#(
  parameter int NUM_ALERTS = 3,
  parameter int MAX_NOTES  = 4,
  localparam int ID_W = (NUM_ALERTS > 1) ? $clog2(NUM_ALERTS) : 1,
  localparam int NIW  = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1
) (
  input  logic [ID_W-1:0] id,
  input  logic [NIW-1:0]  idx,
  output note_t           note
);

  // The final slot always ends the melody so the note index never overflows.
  always_comb begin
    note = melody_note(32'(id), 32'(idx));
    if (idx == NIW'(MAX_NOTES - 1)) begin
      note.last = 1'b1;
    end
  end

endmodule

// File: rtl/piezo_seq.sv
// rtl/piezo_seq.sv - prioritised alert melody sequencer driving a piezo pair
module piezo_seq
  import piezo_pkg::*;
#(
  parameter int NUM_ALERTS = 3,
  parameter int MAX_NOTES  = 4,
  parameter int TICK_SHIFT = 20,
  parameter int REST_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  piezo_seq_if.slave  bus
);

  localparam int ID_W = (NUM_ALERTS > 1) ? $clog2(NUM_ALERTS) : 1;
  localparam int NIW  = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;
  localparam int TCW  = ($clog2(REST_TICKS + 1) > 8) ? $clog2(REST_TICKS + 1) : 8;
  localparam logic [TCW-1:0] REST_LAST = TCW'((REST_TICKS > 0) ? REST_TICKS - 1 : 0);

  state_t                state_q, state_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [NIW-1:0]        idx_q, idx_d;
  logic [TICK_SHIFT-1:0] pre_q, pre_d;
  logic [TCW-1:0]        tick_q, tick_d;
  logic [15:0]           tone_cnt_q, tone_cnt_d;
  logic                  tone_q, tone_d;

  logic [ID_W-1:0] winner;
  logic            req_any;
  note_t           cur;
  logic            tick;
  logic [TCW-1:0]  dur_last;
  logic            note_end;
  logic            rest_end;
  logic            preempt;
  logic            restart;
  logic            sounding;

  always_comb begin
    winner = '0;
    for (int i = 0; i < NUM_ALERTS; i++) begin
      if (bus.alert_req[i]) winner = ID_W'(i);
    end
  end

  assign req_any = |bus.alert_req;

  piezo_note_rom #(
    .NUM_ALERTS (NUM_ALERTS),
    .MAX_NOTES  (MAX_NOTES)
  ) u_rom (
    .id   (id_q),
    .idx  (idx_q),
    .note (cur)
  );

  // A zero duration still plays for one tick.
  assign tick     = &pre_q;
  assign dur_last = (cur.dur == 8'd0) ? '0 : TCW'(cur.dur - 8'd1);
  assign note_end = (state_q == S_NOTE) && tick && (tick_q == dur_last);
  assign rest_end = (state_q == S_REST) && tick && (tick_q == REST_LAST);
  assign preempt  = (state_q != S_IDLE) && req_any && (winner > id_q);

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    idx_d      = idx_q;
    pre_d      = pre_q + 1'b1;
    tick_d     = tick ? tick_q + 1'b1 : tick_q;
    tone_cnt_d = tone_cnt_q;
    tone_d     = tone_q;
    restart    = 1'b0;

    if (state_q == S_NOTE && cur.half_period != 16'd0) begin
      if (tone_cnt_q == cur.half_period - 16'd1) begin
        tone_cnt_d = '0;
        tone_d     = ~tone_q;
      end else begin
        tone_cnt_d = tone_cnt_q + 16'd1;
      end
    end

    if (bus.mute) begin
      state_d = S_IDLE;
      restart = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          restart = 1'b1;
          if (req_any) begin
            state_d = S_NOTE;
            id_d    = winner;
            idx_d   = '0;
          end
        end
        S_NOTE: begin
          if (preempt) begin
            id_d    = winner;
            idx_d   = '0;
            restart = 1'b1;
          end else if (note_end) begin
            restart = 1'b1;
            if (!cur.last)    idx_d   = idx_q + 1'b1;
            else if (req_any) state_d = S_REST;
            else              state_d = S_IDLE;
          end
        end
        S_REST: begin
          if (preempt || rest_end) begin
            restart = 1'b1;
            if (req_any) begin
              state_d = S_NOTE;
              id_d    = winner;
              idx_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          restart = 1'b1;
        end
      endcase
    end

    // Every note and rest begins from a clean prescaler and a high tone phase.
    if (restart) begin
      pre_d      = '0;
      tick_d     = '0;
      tone_cnt_d = '0;
      tone_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      id_q       <= '0;
      idx_q      <= '0;
      pre_q      <= '0;
      tick_q     <= '0;
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      idx_q      <= idx_d;
      pre_q      <= pre_d;
      tick_q     <= tick_d;
      tone_cnt_q <= tone_cnt_d;
      tone_q     <= tone_d;
    end
  end

  assign sounding      = (state_q == S_NOTE) && (cur.half_period != 16'd0);
  assign bus.piezo     = sounding & tone_q;
  assign bus.piezo_n   = sounding & ~tone_q;
  assign bus.playing   = (state_q != S_IDLE);
  assign bus.active_id = id_q;

endmodule

// File: tb/tb_piezo_seq.sv
// tb/tb_piezo_seq.sv - scoreboard bench for piezo_seq with directed scenarios
module tb_piezo_seq;

  typedef struct {
    int         cyc;
    logic       p;
    logic       pn;
    logic       pl;
    logic [1:0] id;
    string      tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  piezo_seq_if #(.NUM_ALERTS(3)) bus ();

  piezo_seq #(
    .NUM_ALERTS (3),
    .MAX_NOTES  (4),
    .TICK_SHIFT (4),
    .REST_TICKS (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic p, input logic pn, input logic pl,
                      input logic [1:0] id, input string tag);
    exp_t e;
    e.cyc = c; e.p = p; e.pn = pn; e.pl = pl; e.id = id; e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Tone phase k of a note is high for the first half_period cycles, then alternates.
  task automatic push_tone(input int c0, input int hp, input int len,
                           input logic [1:0] id, input string tag);
    for (int k = 0; k < len; k++) begin
      logic ph;
      ph = ((k / hp) % 2) == 0;
      push(c0 + k, ph, ~ph, 1'b1, id, tag);
    end
  endtask

  task automatic push_quiet(input int c0, input int len, input logic pl,
                            input logic [1:0] id, input string tag);
    for (int k = 0; k < len; k++) push(c0 + k, 1'b0, 1'b0, pl, id, tag);
  endtask

  task automatic chk(input string tag, input string field, input int c,
                     input logic [3:0] got, input logic [3:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s.%s cycle %0d: got %0h expected %0h", tag, field, c, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) step();
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s missed sample: cycle %0d expected at %0d", mon_e.tag, cyc, mon_e.cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      mon_e = exp_q.pop_front();
      chk(mon_e.tag, "piezo",     cyc, {3'b0, bus.piezo},     {3'b0, mon_e.p});
      chk(mon_e.tag, "piezo_n",   cyc, {3'b0, bus.piezo_n},   {3'b0, mon_e.pn});
      chk(mon_e.tag, "playing",   cyc, {3'b0, bus.playing},   {3'b0, mon_e.pl});
      chk(mon_e.tag, "active_id", cyc, {2'b0, bus.active_id}, {2'b0, mon_e.id});
    end
  end

  initial begin
    int s;
    int p;
    int guard;
    rst           = 1'b1;
    bus.alert_req = 3'b000;
    bus.mute      = 1'b0;

    // Reset, then a long quiet idle stretch.
    push_quiet(1, 202, 1'b0, 2'd0, "reset_idle");
    step();
    step();
    rst = 1'b0;
    wait_cyc(202);

    // Single alert: one 64-cycle tone, 64-cycle rest, repeat, then released.
    bus.alert_req = 3'b001;
    s = cyc + 1;
    push_tone(s, 8, 64, 2'd0, "single_n0");
    push_quiet(s + 64, 64, 1'b1, 2'd0, "single_rest");
    push_tone(s + 128, 8, 64, 2'd0, "single_rep");
    push_quiet(s + 192, 4, 1'b0, 2'd0, "single_idle");
    wait_cyc(s + 140);
    bus.alert_req = 3'b000;
    wait_cyc(s + 195);

    // Two-note melody, one repeat, request dropped mid note 1.
    bus.alert_req = 3'b010;
    s = cyc + 1;
    push_tone(s, 6, 32, 2'd1, "two_n0");
    push_tone(s + 32, 4, 32, 2'd1, "two_n1");
    push_quiet(s + 64, 64, 1'b1, 2'd1, "two_rest");
    push_tone(s + 128, 6, 32, 2'd1, "two_rep_n0");
    push_tone(s + 160, 4, 32, 2'd1, "two_rep_n1");
    push_quiet(s + 192, 8, 1'b0, 2'd1, "two_idle");
    wait_cyc(s + 170);
    bus.alert_req = 3'b000;
    wait_cyc(s + 199);

    // Preemption of id0 by id2 mid note.
    bus.alert_req = 3'b001;
    s = cyc + 1;
    p = s + 21;
    push_tone(s, 8, 21, 2'd0, "pre_id0");
    push_tone(p, 3, 16, 2'd2, "pre_n0");
    push_quiet(p + 16, 16, 1'b1, 2'd2, "pre_n1");
    push_tone(p + 32, 3, 16, 2'd2, "pre_n2");
    push_quiet(p + 48, 8, 1'b0, 2'd2, "pre_idle");
    wait_cyc(s + 20);
    bus.alert_req = 3'b101;
    wait_cyc(p + 40);
    bus.alert_req = 3'b000;
    wait_cyc(p + 55);

    // Mute pulse mid note, playback restarts at note 0 after release.
    bus.alert_req = 3'b010;
    s = cyc + 1;
    push_tone(s, 6, 10, 2'd1, "mute_pre");
    push_quiet(s + 10, 5, 1'b0, 2'd1, "mute_on");
    push_tone(s + 15, 6, 32, 2'd1, "mute_n0");
    push_tone(s + 47, 4, 32, 2'd1, "mute_n1");
    push_quiet(s + 79, 4, 1'b0, 2'd1, "mute_idle");
    wait_cyc(s + 9);
    bus.mute = 1'b1;
    wait_cyc(s + 14);
    bus.mute = 1'b0;
    wait_cyc(s + 20);
    bus.alert_req = 3'b000;
    wait_cyc(s + 82);

    // Reset during REST returns every output to its reset value.
    bus.alert_req = 3'b010;
    s = cyc + 1;
    push_tone(s, 6, 32, 2'd1, "rrst_n0");
    push_tone(s + 32, 4, 32, 2'd1, "rrst_n1");
    push_quiet(s + 64, 17, 1'b1, 2'd1, "rrst_rest");
    push_quiet(s + 81, 10, 1'b0, 2'd0, "rrst_reset");
    wait_cyc(s + 80);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.alert_req = 3'b000;
    wait_cyc(s + 90);

    guard = 0;
    while (exp_q.size() > 0 && guard < 500) begin
      step();
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected samples left, required 0", exp_q.size());
    end
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
